// File: rtl/board_gen_pkg.sv
// rtl/board_gen_pkg.sv - shared minesweeper board geometry and FSM encodings
package board_gen_pkg;

    localparam int GRID_SIZE   = 8;
    localparam int TOTAL_TILES = GRID_SIZE * GRID_SIZE;
    localparam int INDEX_BITS  = $clog2(TOTAL_TILES);
    localparam int ROWCOL_BITS = $clog2(GRID_SIZE);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLACE = 2'd1,
        ST_COUNT = 2'd2,
        ST_READY = 2'd3
    } board_state_t;

    // True when two row or column coordinates are at most one apart.
    function automatic logic within_one(input int a, input int b);
        return ((a - b) <= 1) && ((b - a) <= 1);
    endfunction

endpackage

// File: rtl/board_gen_lfsr16.sv
// rtl/board_gen_lfsr16.sv - free-running 16-bit LFSR, x^16+x^14+x^13+x^11+1
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= SEED;
        end else begin
            q <= {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
        end
    end

endmodule

// File: rtl/board_gen.sv
// rtl/board_gen.sv - random mine placement around a safe first click, then neighbour counts
module board_gen #(
    parameter int          GRID_SIZE   = board_gen_pkg::GRID_SIZE,
    parameter int          TOTAL_TILES = GRID_SIZE * GRID_SIZE,
    parameter int          NUM_MINES   = 10,
    parameter logic [15:0] SEED        = 16'hACE1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [$clog2(TOTAL_TILES)-1:0] start_index,
    output logic [TOTAL_TILES-1:0]         mine_map,
    output logic [TOTAL_TILES*4-1:0]       adj,
    output logic                           game_ready,
    output logic                           busy
);
    import board_gen_pkg::*;

    localparam int IDX_W = $clog2(TOTAL_TILES);
    localparam int CNT_W = $clog2(NUM_MINES + 1);

    board_state_t     state;
    logic [15:0]      lfsr_q;
    logic             lfsr_unused;
    logic [IDX_W-1:0] safe_idx;
    logic [IDX_W-1:0] tile_cnt;
    logic [IDX_W-1:0] cand;
    logic [IDX_W-1:0] nidx;
    logic [CNT_W-1:0] placed;
    logic             accept;
    logic [3:0]       nsum;
    int               cx, cy, sx, sy;
    int               tx, ty;

    lfsr16 #(.SEED(SEED)) u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (lfsr_q)
    );

    assign cand        = lfsr_q[IDX_W-1:0];
    assign lfsr_unused = ^lfsr_q[15:IDX_W];

    // Candidate must be on the board, not yet a mine, and outside the clicked 3x3 block.
    always_comb begin
        cx     = int'(cand) % GRID_SIZE;
        cy     = int'(cand) / GRID_SIZE;
        sx     = int'(safe_idx) % GRID_SIZE;
        sy     = int'(safe_idx) / GRID_SIZE;
        accept = (int'(cand) < TOTAL_TILES) && !(within_one(cx, sx) && within_one(cy, sy));
        if (accept) begin
            accept = !mine_map[cand];
        end
    end

    // Coordinate bounds checks keep edge columns from wrapping into the next row.
    always_comb begin
        tx   = int'(tile_cnt) % GRID_SIZE;
        ty   = int'(tile_cnt) / GRID_SIZE;
        nsum = '0;
        nidx = '0;
        for (int dy = -1; dy <= 1; dy++) begin
            for (int dx = -1; dx <= 1; dx++) begin
                if ((dx != 0 || dy != 0) &&
                    (tx + dx) >= 0 && (tx + dx) < GRID_SIZE &&
                    (ty + dy) >= 0 && (ty + dy) < GRID_SIZE) begin
                    nidx = IDX_W'((ty + dy) * GRID_SIZE + tx + dx);
                    nsum = nsum + {3'b000, mine_map[nidx]};
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            mine_map   <= '0;
            adj        <= '0;
            game_ready <= 1'b0;
            busy       <= 1'b0;
            placed     <= '0;
            tile_cnt   <= '0;
            safe_idx   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        safe_idx <= start_index;
                        mine_map <= '0;
                        placed   <= '0;
                        tile_cnt <= '0;
                        busy     <= 1'b1;
                        state    <= ST_PLACE;
                    end
                end
                ST_PLACE: begin
                    if (accept) begin
                        mine_map[cand] <= 1'b1;
                        placed         <= placed + 1'b1;
                        if (placed == CNT_W'(NUM_MINES - 1)) begin
                            state <= ST_COUNT;
                        end
                    end
                end
                ST_COUNT: begin
                    adj[{tile_cnt, 2'b00} +: 4] <= nsum;
                    tile_cnt                    <= tile_cnt + 1'b1;
                    if (tile_cnt == IDX_W'(TOTAL_TILES - 1)) begin
                        busy       <= 1'b0;
                        game_ready <= 1'b1;
                        state      <= ST_READY;
                    end
                end
                ST_READY: begin
                    state <= ST_READY;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_board_gen.sv
// tb/tb_board_gen.sv - randomized board generation checked against a software board model
module tb_board_gen;

    localparam int          G    = 8;
    localparam int          T    = 64;
    localparam int          NM   = 10;
    localparam logic [15:0] SEED = 16'hACE1;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start_a = 1'b0, start_b = 1'b0;
    logic [5:0]   idx_a = '0, idx_b = '0;
    logic [63:0]  map_a, map_b;
    logic [255:0] adj_a, adj_b;
    logic         ready_a, ready_b, busy_a, busy_b;

    int checks   = 0;
    int failures = 0;
    int edges    = 0;

    always #5 clk = ~clk;

    board_gen #(.GRID_SIZE(G), .TOTAL_TILES(T), .NUM_MINES(NM), .SEED(SEED)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .start_index(idx_a),
        .mine_map(map_a), .adj(adj_a), .game_ready(ready_a), .busy(busy_a)
    );

    board_gen #(.GRID_SIZE(G), .TOTAL_TILES(T), .NUM_MINES(1), .SEED(SEED)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .start_index(idx_b),
        .mine_map(map_b), .adj(adj_b), .game_ready(ready_b), .busy(busy_b)
    );

    function automatic logic [15:0] lstep(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    // es = edge number (1 = first edge after reset release) on which start is sampled.
    function automatic void model_place(input int es, input int sidx, input int nm,
                                        output logic [63:0] map, output int k);
        logic [15:0] v;
        int placed, c, sx, sy;
        v = SEED;
        for (int i = 0; i < es; i++) v = lstep(v);
        map = '0;
        placed = 0;
        k = 0;
        sx = sidx % G;
        sy = sidx / G;
        while (placed < nm && k < 100000) begin
            c = int'(v[5:0]);
            k++;
            if (!((c % G) >= sx - 1 && (c % G) <= sx + 1 && (c / G) >= sy - 1 && (c / G) <= sy + 1)
                && map[c] == 1'b0) begin
                map[c] = 1'b1;
                placed++;
            end
            v = lstep(v);
        end
    endfunction

    function automatic logic [255:0] model_adj(input logic [63:0] map);
        logic [255:0] a;
        int n;
        a = '0;
        for (int y = 0; y < G; y++) begin
            for (int x = 0; x < G; x++) begin
                n = 0;
                for (int yy = y - 1; yy <= y + 1; yy++)
                    for (int xx = x - 1; xx <= x + 1; xx++)
                        if (xx >= 0 && xx < G && yy >= 0 && yy < G && !(xx == x && yy == y))
                            n += int'(map[yy * G + xx]);
                a[(y * G + x) * 4 +: 4] = 4'(n);
            end
        end
        return a;
    endfunction

    task automatic tick();
        @(posedge clk);
        edges++;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        edges = 0;
    endtask

    task automatic check_zero(input string tag);
        checks++; if (map_a !== '0) begin failures++; $display("FAIL %s_map: got %h expected 0", tag, map_a); end
        checks++; if (adj_a !== '0) begin failures++; $display("FAIL %s_adj: got %h expected 0", tag, adj_a); end
        checks++; if (ready_a !== 1'b0) begin failures++; $display("FAIL %s_ready: got %b expected 0", tag, ready_a); end
        checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL %s_busy: got %b expected 0", tag, busy_a); end
    endtask

    // Starts dut_a after 'delay' idle edges; pulse_at >= 0 injects a start(5) that many edges into PLACE.
    task automatic run_board(input int sidx, input int delay, input int pulse_at, input string tag,
                             output logic [63:0] got, output logic [63:0] emap);
        int es, k, pred, first, bad;
        repeat (delay) tick();
        #1 idx_a = 6'(sidx);
        start_a = 1'b1;
        tick();
        es = edges;
        #1 start_a = 1'b0;
        checks++;
        if (busy_a !== 1'b1) begin failures++; $display("FAIL %s_busy_start: got %b expected 1", tag, busy_a); end
        model_place(es, sidx, NM, emap, k);
        pred = es + k + T;
        first = -1;
        while (edges < pred + 4) begin
            if (edges - es == pulse_at) begin
                idx_a = 6'd5;
                start_a = 1'b1;
            end
            tick();
            #1 start_a = 1'b0;
            idx_a = 6'(sidx);
            if (ready_a === 1'b1 && first < 0) first = edges;
        end
        checks++;
        if (first != pred) begin failures++; $display("FAIL %s_ready_edge: got %0d expected %0d", tag, first, pred); end
        checks++;
        if (map_a !== emap) begin failures++; $display("FAIL %s_map: got %h expected %h", tag, map_a, emap); end
        checks++;
        if ($countones(map_a) != NM) begin failures++; $display("FAIL %s_popcount: got %0d expected %0d", tag, $countones(map_a), NM); end
        bad = 0;
        for (int y = sidx / G - 1; y <= sidx / G + 1; y++)
            for (int x = sidx % G - 1; x <= sidx % G + 1; x++)
                if (x >= 0 && x < G && y >= 0 && y < G && map_a[y * G + x] !== 1'b0) bad++;
        checks++;
        if (bad != 0) begin failures++; $display("FAIL %s_safe_block: got %0d mines expected 0", tag, bad); end
        checks++;
        if (adj_a !== model_adj(emap)) begin failures++; $display("FAIL %s_adj: got %h expected %h", tag, adj_a, model_adj(emap)); end
        checks++;
        if (busy_a !== 1'b0 || ready_a !== 1'b1) begin
            failures++; $display("FAIL %s_done_flags: got busy=%b ready=%b expected busy=0 ready=1", tag, busy_a, ready_a);
        end
        got = map_a;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_zero("reset");
        checks++;
        if (map_b !== '0 || ready_b !== 1'b0) begin failures++; $display("FAIL reset_b: got map=%h ready=%b expected 0", map_b, ready_b); end
        @(negedge clk);
        rst = 1'b1;
        edges = 0;
    endtask

    task automatic test_start_zero();
        logic [63:0] g, e;
        do_reset();
        run_board(0, 0, -1, "idx0", g, e);
    endtask

    task automatic test_center();
        logic [63:0] g, e;
        do_reset();
        run_board(27, int'($urandom_range(0, 15)), -1, "idx27", g, e);
        checks++;
        if (adj_a[27 * 4 +: 4] !== 4'd0) begin failures++; $display("FAIL idx27_adj27: got %0d expected 0", adj_a[27 * 4 +: 4]); end
    endtask

    task automatic test_corners();
        logic [63:0] g, e;
        do_reset();
        run_board(63, int'($urandom_range(0, 15)), -1, "idx63", g, e);
        do_reset();
        run_board(7, int'($urandom_range(0, 15)), -1, "idx7", g, e);
    endtask

    // Find a click time where the single mine lands on tile 7, then check edge-column counts.
    task automatic test_forced_map();
        logic [63:0] m;
        int k, found, waited;
        do_reset();
        found = 0;
        for (int es = 1; es <= 3000 && found == 0; es++) begin
            model_place(es, 63, 1, m, k);
            if (m == 64'h80) found = es;
        end
        checks++;
        if (found == 0) begin
            failures++; $display("FAIL forced_search: got no start edge expected one placing tile 7");
        end else begin
            repeat (found - 1) tick();
            #1 idx_b = 6'd63;
            start_b = 1'b1;
            tick();
            #1 start_b = 1'b0;
            waited = 0;
            while (ready_b !== 1'b1 && waited < 400) begin
                tick();
                #1 waited++;
            end
            checks++;
            if (ready_b !== 1'b1) begin failures++; $display("FAIL forced_ready: got %b expected 1", ready_b); end
            checks++;
            if (map_b !== 64'h80) begin failures++; $display("FAIL forced_map: got %h expected %h", map_b, 64'h80); end
            checks++;
            if (adj_b[8 * 4 +: 4] !== 4'd0) begin failures++; $display("FAIL forced_adj8: got %0d expected 0", adj_b[8 * 4 +: 4]); end
            checks++;
            if (adj_b[15 * 4 +: 4] !== 4'd1) begin failures++; $display("FAIL forced_adj15: got %0d expected 1", adj_b[15 * 4 +: 4]); end
            checks++;
            if (adj_b[6 * 4 +: 4] !== 4'd1) begin failures++; $display("FAIL forced_adj6: got %0d expected 1", adj_b[6 * 4 +: 4]); end
        end
    endtask

    task automatic test_restart_ignored();
        logic [63:0] g, e;
        int sidx;
        do_reset();
        sidx = int'($urandom_range(40, 63));
        run_board(sidx, int'($urandom_range(0, 10)), 2, "restart_place", g, e);
        #1 idx_a = 6'd5;
        start_a = 1'b1;
        tick();
        #1 start_a = 1'b0;
        repeat (10) tick();
        #1;
        checks++;
        if (map_a !== e) begin failures++; $display("FAIL restart_ready_map: got %h expected %h", map_a, e); end
        checks++;
        if (adj_a !== model_adj(e)) begin failures++; $display("FAIL restart_ready_adj: got %h expected %h", adj_a, model_adj(e)); end
        checks++;
        if (ready_a !== 1'b1 || busy_a !== 1'b0) begin
            failures++; $display("FAIL restart_ready_flags: got ready=%b busy=%b expected ready=1 busy=0", ready_a, busy_a);
        end
    endtask

    task automatic reset_mid(input int extra, input string tag);
        logic [63:0] g, e, m;
        int sidx, k, es;
        do_reset();
        sidx = int'($urandom_range(0, 63));
        #1 idx_a = 6'(sidx);
        start_a = 1'b1;
        tick();
        es = edges;
        #1 start_a = 1'b0;
        model_place(es, sidx, NM, m, k);
        repeat (extra < 0 ? 3 : k + extra) tick();
        #1;
        checks++;
        if (busy_a !== 1'b1) begin failures++; $display("FAIL %s_busy_before: got %b expected 1", tag, busy_a); end
        #1 rst = 1'b0;
        #1 check_zero(tag);
        @(negedge clk);
        rst = 1'b1;
        edges = 0;
        run_board(int'($urandom_range(0, 63)), 0, -1, {tag, "_after"}, g, e);
    endtask

    task automatic test_repeatability();
        logic [63:0] m1, m2, m3, e, ma, mb;
        int sidx, d, k;
        sidx = 20;
        d = 3;
        for (int t = 0; t < 20; t++) begin
            sidx = int'($urandom_range(0, 63));
            d = int'($urandom_range(0, 10));
            model_place(d + 1, sidx, NM, ma, k);
            model_place(d + 2, sidx, NM, mb, k);
            if (ma != mb) break;
        end
        do_reset();
        run_board(sidx, d, -1, "repeat1", m1, e);
        do_reset();
        run_board(sidx, d, -1, "repeat2", m2, e);
        do_reset();
        run_board(sidx, d + 1, -1, "delayed", m3, e);
        checks++;
        if (m1 !== m2) begin failures++; $display("FAIL repeat_same: got %h expected %h", m2, m1); end
        checks++;
        if (m3 === m1) begin failures++; $display("FAIL repeat_delayed: got %h expected a map different from %h", m3, m1); end
    endtask

    task automatic test_random();
        logic [63:0] g, e;
        for (int i = 0; i < 4; i++) begin
            do_reset();
            run_board(int'($urandom_range(0, 63)), int'($urandom_range(0, 30)), -1, "random", g, e);
        end
    endtask

    initial begin
        test_reset();
        test_start_zero();
        test_center();
        test_corners();
        test_forced_map();
        test_restart_ignored();
        reset_mid(-1, "rst_place");
        reset_mid(20, "rst_count");
        test_repeatability();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/board_gen.md
BOARD_GEN -- requirements
Module: board_gen

Interface
REQ-001 SHALL have parameter GRID_SIZE, default 8, tiles per row and per column.
REQ-002 SHALL have parameter TOTAL_TILES, default GRID_SIZE*GRID_SIZE, board tile count.
REQ-003 SHALL have parameter NUM_MINES, default 10, mines placed per game; legal range 1..TOTAL_TILES-9.
REQ-004 SHALL have parameter SEED, default 16'hACE1, nonzero LFSR reset value.
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port start  input  1  one-cycle first-click pulse.
REQ-008 SHALL have port start_index  input  $clog2(TOTAL_TILES)  first-click tile, row-major (y*GRID_SIZE+x), valid with start.
REQ-009 SHALL have port mine_map  output  TOTAL_TILES  bit i set = mine at tile i.
REQ-010 SHALL have port adj  output  TOTAL_TILES*4  nibble i = mine count among the 8 neighbours of tile i.
REQ-011 SHALL have port game_ready  output  1  board complete and stable.
REQ-012 SHALL have port busy  output  1  generation in progress (PLACE or COUNT).

Function
REQ-013 SHALL implement FSM states IDLE, PLACE, COUNT, READY; reset state IDLE.
REQ-014 SHALL run a 16-bit maximal-length LFSR (x^16+x^14+x^13+x^11+1), free-running every cycle in all states, so the board depends on click timing.
REQ-015 IDLE: on start=1, SHALL latch start_index, clear mine_map, zero the placed counter, and enter PLACE next cycle; IDLE holds all outputs at reset values.
REQ-016 PLACE: SHALL evaluate one candidate per cycle, candidate = LFSR low $clog2(TOTAL_TILES) bits.
REQ-017 SHALL reject a candidate that is >= TOTAL_TILES, already a mine, or inside the 3x3 block centred on the latched index (block clipped at board edges, no wrap).
REQ-018 SHALL set the mine_map bit and increment the placed counter on an accepted candidate; on the accept that brings the count to NUM_MINES, SHALL enter COUNT next cycle.
REQ-019 COUNT: SHALL process tile 0..TOTAL_TILES-1 one per cycle, writing adj nibble with the 8-neighbour mine sum; neighbours off-board contribute 0, column 0 / column GRID_SIZE-1 do not wrap into adjacent rows.
REQ-020 SHALL compute adj for mine tiles too (neighbour count, excluding self).
REQ-021 COUNT SHALL take exactly TOTAL_TILES cycles; game_ready SHALL rise the cycle after the last adj write and the FSM enters READY.
REQ-022 READY: mine_map, adj, game_ready=1 SHALL stay constant until reset.
REQ-023 start SHALL be ignored in PLACE, COUNT, READY (no relatch, no restart).
REQ-024 busy SHALL be 1 exactly in PLACE and COUNT.
REQ-025 The latched 3x3 block SHALL contain no mine in READY; popcount(mine_map) SHALL equal NUM_MINES in READY.

Reset
REQ-026 rst low at any time, including mid-PLACE or mid-COUNT, SHALL immediately force state IDLE, mine_map=0, adj=0, game_ready=0, busy=0, counters=0, LFSR=SEED.
REQ-027 On rst release the first start pulse SHALL be accepted on the first rising clock edge.

Structure
REQ-028 GRID_SIZE, TOTAL_TILES, INDEX_BITS, ROWCOL_BITS and FSM state encodings SHALL live in the shared minesweeper package/include used by render and flood_fill.
REQ-029 The LFSR SHALL be a separate sub-module named lfsr16 (ports clk, rst, q[15:0]); the neighbour sum stays inline.

Verification
REQ-030 Reset, start with start_index=0 -> READY; popcount(mine_map)=10; bits 0,1,8,9 clear; adj matches software model for all 64 tiles.
REQ-031 start_index=27 -> tiles 18,19,20,26,27,28,34,35,36 mine-free; adj[27]=0; game_ready rises exactly 64 cycles after entering COUNT.
REQ-032 start_index=63 and start_index=7 -> corner exclusion clipped correctly, no row wrap in adj (forced map: mine at tile 7 only gives adj[8]=0, adj[15]=1, adj[6]=1).
REQ-033 Second start pulse (index 5) during PLACE and during READY -> latched index unchanged, board unchanged, no restart.
REQ-034 rst asserted mid-PLACE and mid-COUNT -> mine_map=0, adj=0, game_ready=0, busy=0 same edge; subsequent start completes normally.
REQ-035 Two runs identical stimulus and start cycle -> identical boards; start delayed by 1 cycle -> different mine_map.
